// File: rtl/nv_clk_gate_ctrl.sv
// Clock-gate controller: gates the downstream domain after a programmable quiet
// period and restores it on activity, with gate_en driven straight from a flop.
module nv_clk_gate_ctrl #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              cfg_gate_en,
    input  logic [IDLE_W-1:0] cfg_idle_cnt,
    input  logic              test_mode,
    input  logic              busy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              cnt_clr,
    output logic              gate_en,
    output logic              gate_te,
    output logic [1:0]        gate_state,
    output logic [15:0]       gate_off_cnt
);

    localparam int WAKE_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'((WAKE_CYC > 0) ? WAKE_CYC - 1 : 0);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_OFF  = 2'd1,
        ST_WAKE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              activity;
    logic [IDLE_W:0]   idle_inc;
    logic              thr_hit;
    logic              gate_evt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [WAKE_W-1:0] wake_cnt;

    assign activity = req_valid | busy | test_mode | ~cfg_gate_en | (cfg_idle_cnt == '0);
    // One extra bit so the threshold compare and saturation see the true idle_cnt+1.
    assign idle_inc = {1'b0, idle_cnt} + (IDLE_W + 1)'(1);
    assign thr_hit  = idle_inc >= {1'b0, cfg_idle_cnt};
    assign gate_evt = (state == ST_RUN) && (state_nxt == ST_OFF);

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (!activity && thr_hit) begin
                    state_nxt = ST_OFF;
                end
            end
            ST_OFF: begin
                if (activity) begin
                    state_nxt = (WAKE_CYC == 0) ? ST_RUN : ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        gate_state = state;
        gate_te    = test_mode;
        if (state == ST_RUN) begin
            req_ready = 1'b1;
        end
    end

    // gate_en leads the state by one decode so the ICG enable comes off a flop.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            gate_en      <= 1'b1;
            idle_cnt     <= '0;
            wake_cnt     <= '0;
            gate_off_cnt <= '0;
        end else begin
            gate_en <= (state_nxt != ST_OFF);

            if ((state == ST_RUN) && !activity && !gate_evt) begin
                idle_cnt <= idle_inc[IDLE_W] ? '1 : idle_inc[IDLE_W-1:0];
            end else begin
                idle_cnt <= '0;
            end

            if ((state == ST_WAKE) && (state_nxt == ST_WAKE)) begin
                wake_cnt <= wake_cnt + WAKE_W'(1);
            end else begin
                wake_cnt <= '0;
            end

            if (cnt_clr) begin
                gate_off_cnt <= '0;
            end else if (gate_evt && (gate_off_cnt != 16'hFFFF)) begin
                gate_off_cnt <= gate_off_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_nv_clk_gate_ctrl.sv
// Bench for nv_clk_gate_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model of the gating rules.
module tb_nv_clk_gate_ctrl;

    localparam int IDLE_W   = 8;
    localparam int WAKE_CYC = 2;
    localparam int IDLE_MAX = (1 << IDLE_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_gate_en;
    logic [IDLE_W-1:0] cfg_idle_cnt;
    logic              test_mode;
    logic              busy;
    logic              req_valid;
    logic              req_ready;
    logic              cnt_clr;
    logic              gate_en;
    logic              gate_te;
    logic [1:0]        gate_state;
    logic [15:0]       gate_off_cnt;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: 0 RUN, 1 OFF, 2 WAKE; wake_left counts down remaining WAKE cycles.
    int m_state;
    int m_idle;
    int m_wake_left;
    int m_offs;

    nv_clk_gate_ctrl #(.IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .cfg_gate_en    (cfg_gate_en),
        .cfg_idle_cnt   (cfg_idle_cnt),
        .test_mode      (test_mode),
        .busy           (busy),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .cnt_clr        (cnt_clr),
        .gate_en        (gate_en),
        .gate_te        (gate_te),
        .gate_state     (gate_state),
        .gate_off_cnt   (gate_off_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state     = 0;
        m_idle      = 0;
        m_wake_left = 0;
        m_offs      = 0;
    endtask

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit act;
        if (rst) begin
            model_reset();
            return;
        end
        act = req_valid || busy || test_mode || !cfg_gate_en || (cfg_idle_cnt == 0);
        if (m_state == 0) begin
            if (act) begin
                m_idle = 0;
            end else if (m_idle + 1 >= int'(cfg_idle_cnt)) begin
                m_state = 1;
                m_idle  = 0;
                if (m_offs < 65535) m_offs++;
            end else begin
                m_idle = (m_idle + 1 > IDLE_MAX) ? IDLE_MAX : m_idle + 1;
            end
        end else if (m_state == 1) begin
            if (act) begin
                m_wake_left = WAKE_CYC;
                m_state     = (WAKE_CYC == 0) ? 0 : 2;
            end
        end else begin
            m_wake_left--;
            if (m_wake_left == 0) m_state = 0;
        end
        if (cnt_clr) m_offs = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".gate_en"},    32'(gate_en),      32'(m_state != 1));
        chk({tag, ".state"},      32'(gate_state),   32'(m_state));
        chk({tag, ".req_ready"},  32'(req_ready),    32'(m_state == 0));
        chk({tag, ".gate_te"},    32'(gate_te),      32'(test_mode));
        chk({tag, ".off_cnt"},    32'(gate_off_cnt), 32'(m_offs));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_idle();
        cfg_gate_en = 1'b1;
        test_mode   = 1'b0;
        busy        = 1'b0;
        req_valid   = 1'b0;
        cnt_clr     = 1'b0;
    endtask

    // Raise a request in OFF and hold it until RUN accepts it.
    task automatic wake_with_req(input string tag);
        int guard = 0;
        req_valid = 1'b1;
        step(tag);
        while (!req_ready && guard < 20) begin
            step(tag);
            guard++;
        end
        chk({tag, ".wake_done"}, 32'(req_ready), 32'd1);
        step(tag);
        req_valid = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        cfg_idle_cnt = 8'd3;
        set_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        chk("reset.gate_en_const", 32'(gate_en), 32'd1);

        // Idle from the first cycle after reset: gated from cycle 3.
        rst = 1'b0;
        step("idle_c1");
        step("idle_c2");
        chk("idle.still_run", 32'(gate_state), 32'd0);
        step("idle_c3");
        chk("idle.off_state", 32'(gate_state), 32'd1);
        chk("idle.off_en",    32'(gate_en),    32'd0);
        chk("idle.off_cnt",   32'(gate_off_cnt), 32'd1);
        repeat (3) step("off_hold");
        chk("off_hold.en", 32'(gate_en), 32'd0);

        // Wake on a held request: WAKE for two cycles, then RUN and handshake.
        req_valid = 1'b1;
        step("wake_n1");
        chk("wake.n1_en",    32'(gate_en),    32'd1);
        chk("wake.n1_state", 32'(gate_state), 32'd2);
        chk("wake.n1_rdy",   32'(req_ready),  32'd0);
        step("wake_n2");
        chk("wake.n2_state", 32'(gate_state), 32'd2);
        step("wake_n3");
        chk("wake.n3_state", 32'(gate_state), 32'd0);
        chk("wake.n3_rdy",   32'(req_ready),  32'd1);
        step("wake_hs");
        req_valid = 1'b0;

        // Busy in the threshold cycle keeps RUN and restarts the idle count.
        step("busy_i0");
        step("busy_i1");
        busy = 1'b1;
        step("busy_i2");
        busy = 1'b0;
        chk("busy.run", 32'(gate_state), 32'd0);
        step("busy_r0");
        step("busy_r1");
        chk("busy.restart_run", 32'(gate_state), 32'd0);
        chk("busy.restart_en",  32'(gate_en),    32'd1);
        step("busy_r2");
        chk("busy.then_off", 32'(gate_state), 32'd1);
        wake_with_req("busy_wake");

        // Test mode and a zero threshold both hold the clock on.
        test_mode = 1'b1;
        for (int i = 0; i < 300; i++) step("tmode");
        chk("tmode.te",    32'(gate_te),    32'd1);
        chk("tmode.en",    32'(gate_en),    32'd1);
        chk("tmode.state", 32'(gate_state), 32'd0);
        test_mode    = 1'b0;
        cfg_idle_cnt = 8'd0;
        for (int i = 0; i < 300; i++) step("thr0");
        chk("thr0.en",    32'(gate_en),    32'd1);
        chk("thr0.state", 32'(gate_state), 32'd0);

        // Lowering the threshold under the running idle count gates next idle cycle.
        cfg_idle_cnt = 8'd10;
        repeat (5) step("lower_pre");
        cfg_idle_cnt = 8'd2;
        step("lower");
        chk("lower.off", 32'(gate_state), 32'd1);
        wake_with_req("lower_wake");

        // Saturation of gate_off_cnt from a preset near the top.
        cfg_idle_cnt = 8'd1;
        busy = 1'b1;
        step("sat_pre");
        busy = 1'b0;
        force dut.gate_off_cnt = 16'hFFFE;
        #1;
        release dut.gate_off_cnt;
        m_offs = 65534;
        step("sat_1");
        chk("sat.to_ffff", 32'(gate_off_cnt), 32'hFFFF);
        wake_with_req("sat_wake1");
        step("sat_2");
        chk("sat.hold_ffff", 32'(gate_off_cnt), 32'hFFFF);
        wake_with_req("sat_wake2");
        cnt_clr = 1'b1;
        step("clr_vs_inc");
        cnt_clr = 1'b0;
        chk("clr.wins", 32'(gate_off_cnt), 32'd0);
        chk("clr.off",  32'(gate_state),   32'd1);

        // Asynchronous reset while OFF takes effect before the next edge.
        #2 rst = 1'b1;
        #1;
        chk("arst_off.en",    32'(gate_en),      32'd1);
        chk("arst_off.state", 32'(gate_state),   32'd0);
        chk("arst_off.rdy",   32'(req_ready),    32'd1);
        chk("arst_off.cnt",   32'(gate_off_cnt), 32'd0);
        model_reset();
        step("arst_hold");
        rst          = 1'b0;
        cfg_idle_cnt = 8'd3;
        repeat (3) step("arst_recount");
        chk("arst.recount_off", 32'(gate_state), 32'd1);

        // Asynchronous reset while WAKE.
        req_valid = 1'b1;
        step("wk_enter");
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_wake.en",    32'(gate_en),    32'd1);
        chk("arst_wake.state", 32'(gate_state), 32'd0);
        model_reset();
        step("arst_wk_hold");
        rst = 1'b0;

        // Random traffic with clients holding requests until accepted.
        for (int i = 0; i < 4000; i++) begin
            bit pre_ready;
            pre_ready = (m_state == 0);
            busy      = ($urandom_range(0, 4) == 0);
            test_mode = ($urandom_range(0, 60) == 0);
            cnt_clr   = ($urandom_range(0, 50) == 0);
            if ($urandom_range(0, 40) == 0) cfg_gate_en = ~cfg_gate_en;
            if ($urandom_range(0, 30) == 0) cfg_idle_cnt = IDLE_W'($urandom_range(0, 6));
            step("rand");
            if (!(req_valid && !pre_ready)) req_valid = ($urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nv_clk_gate_ctrl.md
NV_CLK_GATE_CTRL -- requirements
Module: nv_clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_W, default 8, width of idle threshold and idle counter.
REQ-002 SHALL have parameter WAKE_CYC, default 2, cycles the clock runs ungated before requests are accepted after wake.
REQ-003 SHALL have one clock and an asynchronous active-high reset: nvdla_core_clk and nvdla_core_rst.
REQ-004 nvdla_core_clk  in  1  free-running clock, upstream of the clock gate cell.
REQ-005 nvdla_core_rst  in  1  asynchronous active-high reset.
REQ-006 cfg_gate_en  in  1  0 forces the clock permanently on.
REQ-007 cfg_idle_cnt  in  IDLE_W  consecutive idle cycles before gating; 0 means never gate.
REQ-008 test_mode  in  1  scan/test mode.
REQ-009 busy  in  1  gated domain has work in flight.
REQ-010 req_valid  in  1  client request into the gated domain.
REQ-011 req_ready  out  1  request accepted this cycle (valid & ready).
REQ-012 cnt_clr  in  1  synchronous clear of gate_off_cnt.
REQ-013 gate_en  out  1  enable to the E pin of the clock gate cell.
REQ-014 gate_te  out  1  enable to the TE pin of the clock gate cell.
REQ-015 gate_state  out  2  current state: 0 RUN, 1 OFF, 2 WAKE.
REQ-016 gate_off_cnt  out  16  number of RUN->OFF transitions, saturating.

Function
REQ-017 SHALL implement FSM with states RUN, OFF and WAKE, held in registers.
REQ-018 gate_en SHALL be driven directly by a dedicated flop, with next value (next_state != OFF), never by combinational decode.
REQ-019 gate_te SHALL equal test_mode combinationally.
REQ-020 req_ready SHALL be 1 only in RUN; never in OFF or WAKE.
REQ-021 "Activity" SHALL be defined as req_valid | busy | test_mode | !cfg_gate_en | (cfg_idle_cnt == 0).
REQ-022 In RUN, idle_cnt SHALL clear to 0 on activity, otherwise increment, saturating at all-ones.
REQ-023 RUN->OFF SHALL occur at the edge where there is no activity and idle_cnt+1 >= cfg_idle_cnt; idle_cnt SHALL clear at that edge.
REQ-024 Activity SHALL take priority over the threshold: if activity occurs in the threshold cycle, the FSM SHALL stay in RUN.
REQ-025 Lowering cfg_idle_cnt below the current idle_cnt SHALL cause gating on the next idle cycle, because the comparison is >=.
REQ-026 In OFF, activity SHALL cause OFF->WAKE at the next edge, and gate_en SHALL be 1 from that edge.
REQ-027 In WAKE, wake_cnt SHALL count WAKE_CYC cycles, then WAKE->RUN; activity SHALL NOT extend or abort WAKE.
REQ-028 With WAKE_CYC = 0, OFF SHALL transition directly to RUN.
REQ-029 A request arriving in OFF or WAKE SHALL be held by the client: req_valid stays asserted until req_ready.
REQ-030 gate_off_cnt SHALL increment on each RUN->OFF transition and saturate at 0xFFFF.
REQ-031 cnt_clr SHALL zero gate_off_cnt; if it coincides with an increment, the clear wins and the result is 0.
REQ-032 In OFF, gate_en SHALL stay 0 while there is no activity.

Reset
REQ-033 Reset assertion SHALL immediately force state RUN, gate_en 1, req_ready 1, idle_cnt 0, wake_cnt 0, gate_off_cnt 0, and gate_state 0.
REQ-034 The clock SHALL therefore run to the gated domain throughout reset, including a reset asserted mid-OFF or mid-WAKE.
REQ-035 After reset deassertion, idle counting SHALL start from 0 on the first clock edge.

Verification
REQ-036 Scenario: cfg_gate_en=1, cfg_idle_cnt=3, all inputs idle from cycle 0 -> gate_en=0 and gate_state=1 from cycle 3, gate_off_cnt=1.
REQ-037 Scenario: in OFF, req_valid=1 at cycle n with WAKE_CYC=2 -> gate_en=1 at n+1, WAKE at n+1..n+2, RUN and req_ready=1 at n+3, handshake completes at n+3.
REQ-038 Scenario: cfg_idle_cnt=3, busy pulses exactly in idle cycle 2 -> stays RUN, gate_en stays 1, idle_cnt restarts at 0.
REQ-039 Scenario: test_mode=1 with idle inputs for 300 cycles -> gate_te=1, gate_en=1, state RUN throughout; cfg_idle_cnt=0 behaves identically.
REQ-040 Scenario: gate_off_cnt preset by 65535 gating events, then one more gating -> stays 0xFFFF; cnt_clr in the same cycle as an increment -> 0.
REQ-041 Scenario: reset asserted asynchronously while in OFF -> gate_en=1 before the next clock edge, state RUN, all counters 0.
